// File: rtl/vc_scheduler.sv
// Two-VC weighted round-robin scheduler: pops show-ahead source FIFOs and
// forwards each word, one cycle later, to the destination selected by data[BW-2].
module vc_scheduler #(
    parameter int BW = 6,
    parameter int WW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          init,
    input  logic [WW-1:0] weight_vc0,
    input  logic [WW-1:0] weight_vc1,
    input  logic          VC0_empty,
    input  logic          VC1_empty,
    input  logic [BW-1:0] VC0_data,
    input  logic [BW-1:0] VC1_data,
    output logic          VC0_rd,
    output logic          VC1_rd,
    input  logic          D0_almost_full,
    input  logic          D1_almost_full,
    input  logic          D0_full,
    input  logic          D1_full,
    output logic          D0_wr,
    output logic          D1_wr,
    output logic [BW-1:0] D0_data_in,
    output logic [BW-1:0] D1_data_in,
    output logic          grant_vc,
    output logic          idle_out,
    output logic          active_out,
    output logic          error_out
);

    typedef enum logic [2:0] {S_RESET, S_INIT, S_IDLE, S_ACTIVE, S_ERROR} state_t;

    localparam logic [WW-1:0] ONE = {{(WW-1){1'b0}}, 1'b1};

    state_t        state, next_state;
    logic [WW-1:0] weight0_q, weight1_q, credit0, credit1;
    logic [WW-1:0] load0, load1, next_credit0, next_credit1, popped_credit;
    logic          elig0, elig1, elig_grant, elig_other, overflow, can_pop;
    logic          pop, pop_vc, pop_dest, other_nonempty, next_grant;
    logic [BW-1:0] pop_data;

    // A zero weight still has to earn one pop per turn.
    assign load0 = (weight0_q == '0) ? ONE : weight0_q;
    assign load1 = (weight1_q == '0) ? ONE : weight1_q;

    assign elig0 = !VC0_empty && !(VC0_data[BW-2] ? D1_almost_full : D0_almost_full);
    assign elig1 = !VC1_empty && !(VC1_data[BW-2] ? D1_almost_full : D0_almost_full);
    assign elig_grant = grant_vc ? elig1 : elig0;
    assign elig_other = grant_vc ? elig0 : elig1;

    assign overflow = (D0_wr && D0_full) || (D1_wr && D1_full);
    assign can_pop  = !reset && (state == S_ACTIVE) && !init && !overflow;

    // The granted VC goes first; an ineligible grant yields to the other VC at once.
    assign pop    = can_pop && (elig_grant || elig_other);
    assign pop_vc = (can_pop && !elig_grant && elig_other) ? ~grant_vc : grant_vc;

    assign pop_data       = pop_vc ? VC1_data : VC0_data;
    assign pop_dest       = pop_data[BW-2];
    assign other_nonempty = pop_vc ? !VC0_empty : !VC1_empty;

    assign VC0_rd = pop && !pop_vc;
    assign VC1_rd = pop && pop_vc;

    always_comb begin
        next_grant    = grant_vc;
        next_credit0  = credit0;
        next_credit1  = credit1;
        popped_credit = '0;
        if (pop_vc != grant_vc) begin
            next_grant   = pop_vc;
            next_credit0 = load0;
            next_credit1 = load1;
        end
        if (pop_vc) begin
            next_credit1  = next_credit1 - ONE;
            popped_credit = next_credit1;
        end else begin
            next_credit0  = next_credit0 - ONE;
            popped_credit = next_credit0;
        end
        // Exhausted credit hands the grant over only if the other side has work.
        if (popped_credit == '0) begin
            next_credit0 = load0;
            next_credit1 = load1;
            if (other_nonempty) begin
                next_grant = ~pop_vc;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_RESET:  next_state = S_INIT;
            S_INIT: begin
                if (overflow)   next_state = S_ERROR;
                else if (!init) next_state = S_IDLE;
            end
            S_IDLE: begin
                if (overflow)                     next_state = S_ERROR;
                else if (init)                    next_state = S_INIT;
                else if (!VC0_empty || !VC1_empty) next_state = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (overflow)                    next_state = S_ERROR;
                else if (init)                   next_state = S_INIT;
                else if (VC0_empty && VC1_empty) next_state = S_IDLE;
            end
            S_ERROR:  next_state = S_ERROR;
            default:  next_state = S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_RESET;
            weight0_q  <= '0;
            weight1_q  <= '0;
            credit0    <= '0;
            credit1    <= '0;
            grant_vc   <= 1'b0;
            D0_wr      <= 1'b0;
            D1_wr      <= 1'b0;
            D0_data_in <= '0;
            D1_data_in <= '0;
            idle_out   <= 1'b0;
            active_out <= 1'b0;
            error_out  <= 1'b0;
        end else begin
            state      <= next_state;
            idle_out   <= (next_state == S_IDLE);
            active_out <= (next_state == S_ACTIVE);
            error_out  <= (next_state == S_ERROR);
            D0_wr      <= pop && !pop_dest;
            D1_wr      <= pop && pop_dest;
            if (pop && !pop_dest) D0_data_in <= pop_data;
            if (pop && pop_dest)  D1_data_in <= pop_data;
            if (state == S_INIT) begin
                weight0_q <= weight_vc0;
                weight1_q <= weight_vc1;
            end
            if (state == S_IDLE && next_state == S_ACTIVE) begin
                grant_vc <= 1'b0;
                credit0  <= load0;
                credit1  <= load1;
            end else if (pop) begin
                grant_vc <= next_grant;
                credit0  <= next_credit0;
                credit1  <= next_credit1;
            end
        end
    end

endmodule

// File: tb/tb_vc_scheduler.sv
// Randomized and directed bench for vc_scheduler, checked cycle by cycle
// against a queue-based reference model of the WRR scheduling rules.
module tb_vc_scheduler;

    localparam int BW = 6;
    localparam int WW = 4;

    logic          clk = 1'b0;
    logic          reset, init;
    logic [WW-1:0] weight_vc0, weight_vc1;
    logic          VC0_empty, VC1_empty;
    logic [BW-1:0] VC0_data, VC1_data;
    logic          VC0_rd, VC1_rd;
    logic          D0_almost_full, D1_almost_full, D0_full, D1_full;
    logic          D0_wr, D1_wr;
    logic [BW-1:0] D0_data_in, D1_data_in;
    logic          grant_vc, idle_out, active_out, error_out;

    always #5 clk = ~clk;

    vc_scheduler #(.BW(BW), .WW(WW)) dut (
        .clk(clk), .reset(reset), .init(init),
        .weight_vc0(weight_vc0), .weight_vc1(weight_vc1),
        .VC0_empty(VC0_empty), .VC1_empty(VC1_empty),
        .VC0_data(VC0_data), .VC1_data(VC1_data),
        .VC0_rd(VC0_rd), .VC1_rd(VC1_rd),
        .D0_almost_full(D0_almost_full), .D1_almost_full(D1_almost_full),
        .D0_full(D0_full), .D1_full(D1_full),
        .D0_wr(D0_wr), .D1_wr(D1_wr),
        .D0_data_in(D0_data_in), .D1_data_in(D1_data_in),
        .grant_vc(grant_vc), .idle_out(idle_out),
        .active_out(active_out), .error_out(error_out)
    );

    typedef enum int {M_RESET, M_INIT, M_IDLE, M_ACTIVE, M_ERROR} mstate_t;

    mstate_t       m_state;
    bit            m_grant;
    int            m_cred[2];
    int            m_w[2];
    bit            m_wr[2];
    logic [BW-1:0] m_dout[2];

    logic [BW-1:0] vcq0[$], vcq1[$];
    int            dut_log[$];

    bit            rst_i, init_i;
    logic [WW-1:0] w_i[2];
    int            af_pct, fill_pct;
    bit            af_force[2], full_force[2], af_now[2];
    bit            last_pop;
    int            checks, errors;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int qsize(int v);
        return (v == 1) ? vcq1.size() : vcq0.size();
    endfunction

    function automatic logic [BW-1:0] qhead(int v);
        return (v == 1) ? vcq1[0] : vcq0[0];
    endfunction

    function automatic bit eligible(int v);
        logic [BW-1:0] h;
        if (qsize(v) == 0) return 1'b0;
        h = qhead(v);
        return !af_now[h[BW-2]];
    endfunction

    function automatic int eff(int w);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic logic [BW-1:0] mk_word(int dest);
        logic [BW-1:0] w;
        w = BW'($urandom);
        if (dest >= 0) w[BW-2] = dest[0];
        return w;
    endfunction

    task automatic fill(int v, int n, int dest);
        for (int i = 0; i < n; i++) begin
            if (v == 1) vcq1.push_back(mk_word(dest));
            else        vcq0.push_back(mk_word(dest));
        end
    endtask

    task automatic reloadCredits();
        m_cred[0] = eff(m_w[0]);
        m_cred[1] = eff(m_w[1]);
    endtask

    // Reference model: advances one clock given this cycle's inputs and pop choice.
    task automatic modelNext(input int pv, input bit ovf);
        logic [BW-1:0] hd;
        bit            any;
        if (rst_i) begin
            m_state = M_RESET;
            m_grant = 1'b0;
            m_cred  = '{0, 0};
            m_w     = '{0, 0};
            m_wr    = '{0, 0};
            m_dout  = '{'0, '0};
            return;
        end
        any  = (vcq0.size() > 0) || (vcq1.size() > 0);
        m_wr = '{0, 0};
        if (pv >= 0) begin
            hd = qhead(pv);
            m_wr[hd[BW-2]]   = 1'b1;
            m_dout[hd[BW-2]] = hd;
            if (pv != int'(m_grant)) begin
                m_grant = pv[0];
                reloadCredits();
            end
            m_cred[pv] = m_cred[pv] - 1;
            if (m_cred[pv] == 0) begin
                reloadCredits();
                if (qsize(1 - pv) > 0) m_grant = (pv == 0);
            end
        end
        case (m_state)
            M_RESET: m_state = M_INIT;
            M_INIT: begin
                m_w[0] = int'(w_i[0]);
                m_w[1] = int'(w_i[1]);
                if (ovf)          m_state = M_ERROR;
                else if (!init_i) m_state = M_IDLE;
            end
            M_IDLE: begin
                if (ovf)         m_state = M_ERROR;
                else if (init_i) m_state = M_INIT;
                else if (any) begin
                    m_state = M_ACTIVE;
                    m_grant = 1'b0;
                    reloadCredits();
                end
            end
            M_ACTIVE: begin
                if (ovf)         m_state = M_ERROR;
                else if (init_i) m_state = M_INIT;
                else if (!any)   m_state = M_IDLE;
            end
            default: m_state = M_ERROR;
        endcase
    endtask

    // One clock: drive inputs after the edge, check mid-cycle, then advance the model and FIFOs.
    task automatic applyStimulus();
        int pv;
        bit ovf;
        reset      = rst_i;
        init       = init_i;
        weight_vc0 = w_i[0];
        weight_vc1 = w_i[1];
        VC0_empty  = (vcq0.size() == 0);
        VC1_empty  = (vcq1.size() == 0);
        VC0_data   = (vcq0.size() > 0) ? vcq0[0] : BW'($urandom);
        VC1_data   = (vcq1.size() > 0) ? vcq1[0] : BW'($urandom);
        for (int v = 0; v < 2; v++)
            af_now[v] = af_force[v] || (int'($urandom_range(99)) < af_pct);
        D0_almost_full = af_now[0];
        D1_almost_full = af_now[1];
        D0_full        = full_force[0];
        D1_full        = full_force[1];
        #4;
        ovf = (m_wr[0] && full_force[0]) || (m_wr[1] && full_force[1]);
        pv  = -1;
        if (!rst_i && m_state == M_ACTIVE && !init_i && !ovf) begin
            for (int k = 0; k < 2; k++) begin
                int v;
                v = (k == 0) ? int'(m_grant) : 1 - int'(m_grant);
                if (pv < 0 && eligible(v)) pv = v;
            end
        end
        checkOutput("vc_rd", {VC1_rd, VC0_rd}, {pv == 1, pv == 0});
        checkOutput("d_wr", {D1_wr, D0_wr}, {m_wr[1], m_wr[0]});
        checkOutput("d0_data", D0_data_in, m_dout[0]);
        checkOutput("d1_data", D1_data_in, m_dout[1]);
        checkOutput("indicators", {error_out, active_out, idle_out},
                    {m_state == M_ERROR, m_state == M_ACTIVE, m_state == M_IDLE});
        checkOutput("grant_vc", grant_vc, m_grant);
        last_pop = VC0_rd || VC1_rd;
        if (VC0_rd)      dut_log.push_back(0);
        else if (VC1_rd) dut_log.push_back(1);
        modelNext(pv, ovf);
        @(posedge clk);
        #1;
        if (pv == 0) void'(vcq0.pop_front());
        if (pv == 1) void'(vcq1.pop_front());
        if (fill_pct > 0) begin
            if (vcq0.size() < 8 && int'($urandom_range(99)) < fill_pct) vcq0.push_back(mk_word(-1));
            if (vcq1.size() < 8 && int'($urandom_range(99)) < fill_pct) vcq1.push_back(mk_word(-1));
        end
    endtask

    task automatic expectOrder(input string tag, input string pattern, input int total);
        checkOutput({tag, "_count"}, dut_log.size(), total);
        for (int i = 0; i < pattern.len(); i++)
            checkOutput($sformatf("%s_pop%0d", tag, i),
                        (i < dut_log.size()) ? dut_log[i] : 9, pattern[i] - "0");
    endtask

    task automatic configure(input int w0, input int w1);
        init_i = 1'b1;
        w_i[0] = w0[WW-1:0];
        w_i[1] = w1[WW-1:0];
        repeat (3) applyStimulus();
        init_i = 1'b0;
    endtask

    initial begin
        int n;
        checks = 0; errors = 0;
        af_pct = 0; fill_pct = 0;
        af_force = '{0, 0}; full_force = '{0, 0};
        rst_i = 1'b1; init_i = 1'b0;
        w_i = '{'0, '0};
        reset = 1'b1; init = 1'b0;
        weight_vc0 = '0; weight_vc1 = '0;
        VC0_empty = 1'b1; VC1_empty = 1'b1;
        VC0_data = '0; VC1_data = '0;
        D0_almost_full = 1'b0; D1_almost_full = 1'b0;
        D0_full = 1'b0; D1_full = 1'b0;
        m_state = M_RESET; m_grant = 1'b0;
        m_cred = '{0, 0}; m_w = '{0, 0}; m_wr = '{0, 0}; m_dout = '{'0, '0};
        @(posedge clk);
        #1;
        repeat (3) applyStimulus();

        // Weights 2/1, all traffic to D0
        fill(0, 6, 0);
        fill(1, 6, 0);
        rst_i = 1'b0;
        dut_log.delete();
        configure(2, 1);
        repeat (25) applyStimulus();
        expectOrder("wrr21", "001001001111", 12);

        // Drain to idle, then a lone VC1 word wakes the scheduler
        repeat (3) applyStimulus();
        vcq1.push_back(mk_word(1));
        repeat (5) applyStimulus();

        // Non-blocking: VC0 head targets a nearly full D1
        dut_log.delete();
        vcq0.push_back(6'b01_0001);
        vcq1.push_back(6'b10_0001);
        af_force[1] = 1'b1;
        repeat (4) applyStimulus();
        af_force[1] = 1'b0;
        repeat (4) applyStimulus();
        expectOrder("nonblock", "10", 2);

        // Zero weights behave as one: strict alternation
        fill(0, 6, 0);
        fill(1, 6, 0);
        dut_log.delete();
        configure(0, 0);
        repeat (20) applyStimulus();
        expectOrder("wrr00", "010101010101", 12);

        // Weights 3/1
        fill(0, 8, -1);
        fill(1, 8, -1);
        dut_log.delete();
        configure(3, 1);
        repeat (40) applyStimulus();
        expectOrder("wrr31", "00010001", 16);

        // Reset the cycle after a pop drops nothing already presented, then clears all
        fill(0, 4, -1);
        fill(1, 4, -1);
        n = 0;
        last_pop = 1'b0;
        while (!last_pop && n < 20) begin
            applyStimulus();
            n++;
        end
        checkOutput("wait_pop", last_pop, 1'b1);
        rst_i = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("rst_drop_wr", {D1_wr, D0_wr}, 2'b00);
        rst_i = 1'b0;
        vcq0.delete();
        vcq1.delete();

        // Random traffic with backpressure and periodic reconfiguration
        af_pct = 30;
        fill_pct = 35;
        for (int r = 0; r < 4; r++) begin
            configure(int'($urandom_range(15)), int'($urandom_range(15)));
            repeat (150) applyStimulus();
        end

        // Overflow on D0 is sticky until reset
        af_pct = 0;
        fill_pct = 50;
        n = 0;
        while (!m_wr[0] && n < 60) begin
            applyStimulus();
            n++;
        end
        checkOutput("wait_d0_wr", m_wr[0], 1'b1);
        full_force[0] = 1'b1;
        applyStimulus();
        full_force[0] = 1'b0;
        repeat (5) applyStimulus();
        checkOutput("err_sticky", error_out, 1'b1);
        rst_i = 1'b1;
        repeat (2) applyStimulus();
        checkOutput("rst_outputs",
                    {VC1_rd, VC0_rd, D1_wr, D0_wr, D1_data_in, D0_data_in,
                     grant_vc, idle_out, active_out, error_out}, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
